// File: rtl/paddle_ctrl_if.sv
// Signal bundle between the frame/scan source, the paddle generator and the pixel mixer.
// The master drives timing, buttons and ball position; the slave returns the render and position outputs.
interface paddle_ctrl_if;
  logic               fsync;
  logic signed [11:0] hpos;
  logic signed [11:0] vpos;
  logic               btn_pos;
  logic               btn_neg;
  logic               auto_en;
  logic signed [11:0] ball_c;
  logic [2:0][7:0]    pixel;
  logic               active;
  logic signed [11:0] pos_lo;
  logic signed [11:0] pos_hi;

  modport master (
    output fsync, hpos, vpos, btn_pos, btn_neg, auto_en, ball_c,
    input  pixel, active, pos_lo, pos_hi
  );

  modport slave (
    input  fsync, hpos, vpos, btn_pos, btn_neg, auto_en, ball_c,
    output pixel, active, pos_lo, pos_hi
  );
endinterface

// File: rtl/paddle_ctrl.sv
// Pong paddle: per-frame position update (buttons or ball auto-track, ramped velocity,
// edge clamping) and a registered one-cycle-latency renderer.
module paddle_ctrl #(
  parameter int          ORIENT     = 0,
  parameter int          HRES       = 1280,
  parameter int          VRES       = 720,
  parameter int          FIXED_POS  = 0,
  parameter int          PADDLE_LEN = 200,
  parameter int          PADDLE_THK = 20,
  parameter int          VEL_MIN    = 4,
  parameter int          VEL_MAX    = 16,
  parameter int          ACCEL      = 4,
  parameter int          DEADBAND   = 8,
  parameter logic [23:0] COLOR      = 24'hEFE62E
) (
  input logic          pixel_clk,
  input logic          rst,
  paddle_ctrl_if.slave bus
);

  localparam int                 RES      = (ORIENT == 0) ? HRES : VRES;
  localparam logic signed [12:0] POS_MAX  = 13'(RES - PADDLE_LEN);
  localparam logic signed [11:0] POS_INIT = 12'((RES - PADDLE_LEN) / 2);
  localparam logic signed [11:0] LEN_M1   = 12'(PADDLE_LEN - 1);
  localparam logic signed [12:0] HALF_LEN = 13'(PADDLE_LEN / 2);
  localparam logic signed [12:0] DBAND    = 13'(DEADBAND);
  localparam logic signed [11:0] FIX_LO   = 12'(FIXED_POS);
  localparam logic signed [11:0] FIX_HI   = 12'(FIXED_POS + PADDLE_THK - 1);
  localparam logic [7:0]         VMIN     = 8'(VEL_MIN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_P = 2'd1,
    MOVE_N = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         vel_q, vel_d;
  logic signed [11:0] pos_lo_q, pos_lo_d;
  logic signed [11:0] pos_hi_q, pos_hi_d;
  logic [2:0]         sync_p_q, sync_n_q;
  logic               req_p_q, req_n_q;
  logic               active_q, active_d;
  logic [2:0][7:0]    pixel_q, pixel_d;

  logic               want_p_s, want_n_s;
  logic signed [12:0] pos_ext_s, centre_s, ball_ext_s, target_s;
  logic [7:0]         step_s;
  logic signed [11:0] along_s, fixed_s;

  function automatic logic [7:0] vel_ramp(input logic [7:0] v);
    logic [8:0] sum;
    sum = {1'b0, v} + 9'(ACCEL);
    if (sum > 9'(VEL_MAX)) vel_ramp = 8'(VEL_MAX);
    else                   vel_ramp = sum[7:0];
  endfunction

  function automatic logic signed [11:0] clamp_pos(input logic signed [12:0] p);
    if (p < 13'sd0)        clamp_pos = 12'sd0;
    else if (p > POS_MAX)  clamp_pos = POS_MAX[11:0];
    else                   clamp_pos = p[11:0];
  endfunction

  assign pos_ext_s  = {pos_lo_q[11], pos_lo_q};
  assign centre_s   = pos_ext_s + HALF_LEN;
  assign ball_ext_s = {bus.ball_c[11], bus.ball_c};
  assign pos_hi_d   = pos_lo_d + LEN_M1;

  // Button synchronizers and sticky per-frame request latches
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      sync_p_q <= 3'b000;
      sync_n_q <= 3'b000;
      req_p_q  <= 1'b0;
      req_n_q  <= 1'b0;
    end else begin
      sync_p_q <= {sync_p_q[1:0], bus.btn_pos};
      sync_n_q <= {sync_n_q[1:0], bus.btn_neg};
      req_p_q  <= bus.fsync ? 1'b0 : (req_p_q | sync_p_q[2]);
      req_n_q  <= bus.fsync ? 1'b0 : (req_n_q | sync_n_q[2]);
    end
  end

  // Direction wanted this frame: ball tracking with deadband, or exclusive button request
  always_comb begin
    want_p_s = 1'b0;
    want_n_s = 1'b0;
    if (bus.auto_en) begin
      if (ball_ext_s > centre_s + DBAND) begin
        want_p_s = 1'b1;
      end else if (ball_ext_s < centre_s - DBAND) begin
        want_n_s = 1'b1;
      end else begin
        want_p_s = 1'b0;
      end
    end else begin
      want_p_s = req_p_q & ~req_n_q;
      want_n_s = req_n_q & ~req_p_q;
    end
  end

  // Frame-rate state machine: a repeat direction ramps velocity, a new direction restarts it
  always_comb begin
    state_d  = state_q;
    vel_d    = vel_q;
    pos_lo_d = pos_lo_q;
    step_s   = 8'd0;
    target_s = pos_ext_s;
    if (!bus.fsync) begin
      state_d = state_q;
    end else if (want_p_s || want_n_s) begin
      state_d = want_p_s ? MOVE_P : MOVE_N;
      if (state_d == state_q) begin
        step_s = vel_q;
        vel_d  = vel_ramp(vel_q);
      end else begin
        step_s = VMIN;
        vel_d  = vel_ramp(VMIN);
      end
      if (want_p_s) target_s = pos_ext_s + $signed({5'd0, step_s});
      else          target_s = pos_ext_s - $signed({5'd0, step_s});
      pos_lo_d = clamp_pos(target_s);
    end else begin
      state_d = IDLE;
      vel_d   = VMIN;
    end
  end

  // Paddle hit test on the incoming scan coordinate; signed so blanking (negative) misses
  always_comb begin
    along_s  = (ORIENT == 0) ? bus.hpos : bus.vpos;
    fixed_s  = (ORIENT == 0) ? bus.vpos : bus.hpos;
    active_d = (along_s >= pos_lo_q) && (along_s <= pos_hi_q) &&
               (fixed_s >= FIX_LO)   && (fixed_s <= FIX_HI);
    pixel_d  = active_d ? COLOR : 24'h000000;
  end

  // State, velocity, position and render registers
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vel_q    <= VMIN;
      pos_lo_q <= POS_INIT;
      pos_hi_q <= POS_INIT + LEN_M1;
      active_q <= 1'b0;
      pixel_q  <= '0;
    end else begin
      state_q  <= state_d;
      vel_q    <= vel_d;
      pos_lo_q <= pos_lo_d;
      pos_hi_q <= pos_hi_d;
      active_q <= active_d;
      pixel_q  <= pixel_d;
    end
  end

  assign bus.pos_lo = pos_lo_q;
  assign bus.pos_hi = pos_hi_q;
  assign bus.active = active_q;
  assign bus.pixel  = pixel_q;

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
Parametrised paddle generator for the Pong HDMI pipeline. It supports horizontal or vertical orientation, an accelerating velocity profile, exact edge clamping, and an auto-track mode that follows a ball coordinate. Position updates once per frame on fsync. Registered RGB and active outputs feed the pixel mixer.

Parameters:
ORIENT, 0, 0 = paddle moves along h (fixed v band); 1 = moves along v (fixed h band)
HRES, 1280, horizontal resolution in pixels
VRES, 720, vertical resolution in pixels
FIXED_POS, 0, coordinate of the paddle's near edge on the fixed axis
PADDLE_LEN, 200, extent along the movement axis
PADDLE_THK, 20, extent along the fixed axis
VEL_MIN, 4, first-frame step in pixels/frame
VEL_MAX, 16, velocity ceiling
ACCEL, 4, velocity increment per consecutive same-direction frame
DEADBAND, 8, auto-mode tolerance in pixels
COLOR, 24'hEFE62E, RGB888 fill colour

Ports:
pixel_clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
fsync  in  1  one-cycle frame-start pulse
hpos  in  12 signed  current pixel x
vpos  in  12 signed  current pixel y
btn_pos  in  1  async button: move toward +axis (right or down)
btn_neg  in  1  async button: move toward -axis (left or up)
auto_en  in  1  1 = auto-track ball_c; buttons ignored
ball_c  in  12 signed  ball centre coordinate on the movement axis
pixel  out  3x8  [2]=R [1]=G [0]=B; COLOR when active, else 0
active  out  1  current pixel lies inside the paddle
pos_lo  out  12 signed  paddle low edge on the movement axis
pos_hi  out  12 signed  pos_lo + PADDLE_LEN - 1

Behaviour:
- Reset: state IDLE, vel=VEL_MIN, pos_lo=(RES-PADDLE_LEN)/2, where RES = HRES if ORIENT=0, else VRES. active=0, pixel=0, request latches cleared, synchronizers cleared.
- Inputs: btn_pos and btn_neg each pass through a 3-FF synchronizer. Request flags req_p and req_n set while fsync=0 when their synchronized input is high. They are sticky until fsync and cleared on fsync. A press arriving on the fsync cycle counts toward the next frame.
- Frame decision (on fsync), manual mode:
  - req_p&~req_n gives +.
  - req_n&~req_p gives -.
  - Both set or neither set gives none.
- Frame decision (on fsync), auto mode, with centre c = pos_lo + PADDLE_LEN/2:
  - ball_c > c+DEADBAND gives +.
  - ball_c < c-DEADBAND gives -.
  - Otherwise none.
- State machine: IDLE, MOVE_P, MOVE_N. Evaluated only on fsync.
  - none: go to IDLE, vel=VEL_MIN, no move.
  - Same direction as current MOVE_x: step by current vel, then vel=min(vel+ACCEL, VEL_MAX).
  - New direction (from IDLE or a reversal): step by VEL_MIN, then vel=min(VEL_MIN+ACCEL, VEL_MAX).
- Step arithmetic: compute the signed 13-bit value pos_lo±step, then clamp to [0, RES-PADDLE_LEN]. Hitting a clamp does not reset vel.
- A change of auto_en mid-frame takes effect at the next fsync. The state machine carries over unchanged.
- pos_lo and pos_hi register one cycle after the fsync cycle.
- Render, 1-cycle latency:
  - Along-axis coordinate a = hpos (ORIENT=0) or vpos (ORIENT=1); the other coordinate is f.
  - active <= pos_lo<=a<=pos_hi && FIXED_POS<=f<=FIXED_POS+PADDLE_THK-1, using signed compares so negative blanking coordinates are inactive.
  - pixel registers in the same cycle as active.
- Reset asserted mid-frame or mid-move overrides everything on that cycle.

Test Plan:
1. Reset with defaults -> pos_lo=540, pos_hi=739, active=0, pixel=0. Scan (600,10) -> active=1 and pixel=EF,E6,2E one cycle later. Scan (600,20) -> active=0.
2. Hold btn_pos for 5 frames -> pos_lo 544, 552, 564, 580, 596; vel saturates at 16.
3. From pos_lo=1070 with vel=16, press + -> pos_lo=1080. A further + press -> 1080 (clamped). Mirror case at 0 with btn_neg -> 0.
4. Both buttons held -> no move, vel=4. Reversal after 3 + frames (pos_lo=564) -> next frame 560.
5. A pulse of btn_pos lasting 5 clocks mid-frame -> one step of +4 at the next fsync. A pulse on the fsync cycle only -> no move that frame, +4 the following frame.
6. auto_en=1, ball_c=100, start at 540 -> moves - with ramp 4, 8, 12, 16, 16..., then stops when the centre is within ±8 of 100. ORIENT=1 instance: vpos compare used and clamp at VRES-PADDLE_LEN=520.
